// File: rtl/nfc_page_reader.sv
// NAND page-read engine: issues 00h + 3 address cycles, waits out R/B busy,
// then streams PAGE_BYTES bytes over a valid/ready interface using RE pulses.
module nfc_page_reader #(
  parameter int PAGE_BYTES = 512,
  parameter int ROW_BITS   = 9,
  parameter int WB_WAIT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROW_BITS-1:0] page_addr,
  output logic                busy,
  output logic                page_done,
  output logic [7:0]          dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  inout  wire  [7:0]          F_IO_A,
  output logic                F_CLE_A,
  output logic                F_ALE_A,
  output logic                F_REN_A,
  output logic                F_WEN_A,
  input  logic                F_RB_A
);

  // state   | meaning
  // IDLE    | waiting for start
  // CMD     | write 00h with CLE (WEN low, then WEN high)
  // ADR0-2  | write column, row low, row high with ALE
  // WAIT_LO | wait for R/B to fall, bounded by WB_WAIT
  // WAIT_HI | wait for R/B to rise (array load finished)
  // RD_LO   | RE low for 2 cycles, byte captured at the end
  // RD_HI   | RE high, byte presented
  // HOLD    | byte held until downstream accepts
  // DONE    | one-cycle page_done pulse
  typedef enum logic [3:0] {
    IDLE, CMD, ADR0, ADR1, ADR2, WAIT_LO, WAIT_HI, RD_LO, RD_HI, HOLD, DONE
  } state_t;

  localparam int CNT_W = $clog2(PAGE_BYTES) + 1;
  localparam int WB_W  = $clog2(WB_WAIT + 1);

  state_t            state, state_n;
  logic              ph, ph_n;
  logic [CNT_W-1:0]  byte_cnt, cnt_n;
  logic [WB_W-1:0]   wait_cnt, wait_n;
  logic [ROW_BITS-1:0] row_q;
  logic [15:0]       row_ext;
  logic              rb_meta, rb_sync;
  logic              cap;
  logic              io_oe;
  logic [7:0]        io_out;

  assign row_ext = 16'(row_q);
  assign F_IO_A  = io_oe ? io_out : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ph       <= 1'b0;
      byte_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      byte_cnt <= cnt_n;
      wait_cnt <= wait_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      dout    <= 8'h00;
      rb_meta <= 1'b1;
      rb_sync <= 1'b1;
    end else begin
      rb_meta <= F_RB_A;
      rb_sync <= rb_meta;
      if (state == IDLE && start) row_q <= page_addr;
      if (cap) dout <= F_IO_A;
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph;
    cnt_n   = byte_cnt;
    wait_n  = wait_cnt;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CMD;
          ph_n    = 1'b0;
          cnt_n   = '0;
        end
      end
      CMD, ADR0, ADR1: begin
        if (ph) begin
          ph_n    = 1'b0;
          state_n = (state == CMD) ? ADR0 : (state == ADR0) ? ADR1 : ADR2;
        end else begin
          ph_n = 1'b1;
        end
      end
      ADR2: begin
        if (ph) begin
          ph_n    = 1'b0;
          state_n = WAIT_LO;
          wait_n  = WB_W'(WB_WAIT - 1);
        end else begin
          ph_n = 1'b1;
        end
      end
      // Flash may finish before the sync chain ever sees busy; give up after WB_WAIT cycles.
      WAIT_LO: begin
        if (!rb_sync)            state_n = WAIT_HI;
        else if (wait_cnt == '0) state_n = RD_LO;
        else                     wait_n  = wait_cnt - 1'b1;
      end
      WAIT_HI: begin
        if (rb_sync) state_n = RD_LO;
      end
      RD_LO: begin
        if (ph) begin
          ph_n    = 1'b0;
          cap     = 1'b1;
          state_n = RD_HI;
        end else begin
          ph_n = 1'b1;
        end
      end
      RD_HI, HOLD: begin
        if (dout_ready) begin
          cnt_n   = byte_cnt + 1'b1;
          state_n = (byte_cnt == CNT_W'(PAGE_BYTES - 1)) ? DONE : RD_LO;
        end else begin
          state_n = HOLD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    F_WEN_A    = 1'b1;
    F_REN_A    = 1'b1;
    F_CLE_A    = 1'b0;
    F_ALE_A    = 1'b0;
    io_oe      = 1'b0;
    io_out     = 8'h00;
    busy       = (state != IDLE);
    page_done  = (state == DONE);
    dout_valid = (state == RD_HI) || (state == HOLD);
    case (state)
      CMD: begin
        F_CLE_A = 1'b1;
        F_WEN_A = ph;
        io_oe   = 1'b1;
      end
      ADR0: begin
        F_ALE_A = 1'b1;
        F_WEN_A = ph;
        io_oe   = 1'b1;
      end
      ADR1: begin
        F_ALE_A = 1'b1;
        F_WEN_A = ph;
        io_oe   = 1'b1;
        io_out  = row_ext[7:0];
      end
      ADR2: begin
        F_ALE_A = 1'b1;
        F_WEN_A = ph;
        io_oe   = 1'b1;
        io_out  = row_ext[15:8];
      end
      RD_LO:   F_REN_A = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nfc_page_reader.sv
// Directed bench for nfc_page_reader with a behavioural NAND model on bus A.
module tb_nfc_page_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] page_addr = '0;
  logic       dout_ready = 1'b1;
  logic       busy, page_done, dout_valid;
  logic [7:0] dout;
  logic       F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A;
  logic       F_RB_A;
  tri1  [7:0] flash_io;

  int vec = 0;
  int miscmp = 0;

  always #10 clk = ~clk;

  nfc_page_reader dut (
    .clk(clk), .rst(rst), .start(start), .page_addr(page_addr),
    .busy(busy), .page_done(page_done), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .F_IO_A(flash_io), .F_CLE_A(F_CLE_A),
    .F_ALE_A(F_ALE_A), .F_REN_A(F_REN_A), .F_WEN_A(F_WEN_A), .F_RB_A(F_RB_A)
  );

  function automatic logic [7:0] mem_f(input int a);
    return 8'((a * 37) ^ ((a >> 9) * 11) ^ (a >> 3));
  endfunction

  // ---------------- flash model ----------------
  bit         rb_mode = 1'b1;
  int         fl_page = 0;
  int         col = 0;
  int         ale_idx = 0;
  int         cmd_cnt = 0;
  int         wr_n = 0;
  logic [9:0] wr_log [8];
  logic [7:0] adr [3];
  int         rb_st = 0;
  int         rb_t = 0;
  logic       rb = 1'b1;
  logic       prev_wen = 1'b1;
  logic       prev_ren = 1'b1;
  logic [7:0] fl_data;

  assign F_RB_A   = rb;
  assign fl_data  = mem_f(fl_page * 512 + col);
  assign flash_io = (!F_REN_A) ? fl_data : 8'bz;

  always @(negedge clk) begin
    if (rb_st == 1) begin
      rb_t--;
      if (rb_t == 0) begin rb = 1'b0; rb_t = 20; rb_st = 2; end
    end else if (rb_st == 2) begin
      rb_t--;
      if (rb_t == 0) begin rb = 1'b1; rb_st = 0; end
    end
    if (!prev_wen && F_WEN_A) begin
      if (F_CLE_A && flash_io == 8'h00) begin
        cmd_cnt++;
        wr_n = 0; col = 0; ale_idx = 0; rb = 1'b1; rb_st = 0;
      end
      if (wr_n < 8) begin
        wr_log[wr_n] = {F_CLE_A, F_ALE_A, flash_io};
        wr_n++;
      end
      if (F_ALE_A && ale_idx < 3) begin
        adr[ale_idx] = flash_io;
        ale_idx++;
        if (ale_idx == 3) begin
          fl_page = {adr[2][0], adr[1]};
          if (rb_mode) begin rb_st = 1; rb_t = 3; end
        end
      end
    end
    if (!prev_ren && F_REN_A) col++;
    prev_wen = F_WEN_A;
    prev_ren = F_REN_A;
  end

  // ---------------- stream monitor ----------------
  logic       new_page = 1'b0;
  int         exp_page = 0;
  int         cyc = 0;
  int         hs_cnt = 0;
  int         data_bad = 0;
  int         hold_bad = 0;
  int         done_cnt = 0;
  int         done_gap = 0;
  int         overlap = 0;
  int         last_hs = 0;
  int         min_gap = 0;
  int         max_gap = 0;
  logic       pv_valid = 1'b0;
  logic       pv_hs = 1'b0;
  logic [7:0] pv_dout = '0;

  always @(negedge clk) begin
    cyc++;
    if (new_page) begin
      hs_cnt = 0; data_bad = 0; hold_bad = 0; done_cnt = 0; done_gap = -1;
      overlap = 0; min_gap = 1000000; max_gap = 0;
    end
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      if (dout_valid && dout_ready) begin
        if (dout !== mem_f(exp_page * 512 + hs_cnt)) data_bad++;
        if (hs_cnt > 0) begin
          if (cyc - last_hs < min_gap) min_gap = cyc - last_hs;
          if (cyc - last_hs > max_gap) max_gap = cyc - last_hs;
        end
        last_hs = cyc;
        hs_cnt++;
      end
      if (dout_valid && !dout_ready && F_REN_A !== 1'b1) hold_bad++;
      if (pv_valid && !pv_hs && (!dout_valid || dout !== pv_dout)) hold_bad++;
      if (page_done) begin
        done_cnt++;
        done_gap = cyc - last_hs;
        if (dout_valid && dout_ready) overlap++;
      end
      pv_valid = dout_valid;
      pv_hs    = dout_valid && dout_ready;
      pv_dout  = dout;
    end
  end

  // ---------------- checks and stimulus ----------------
  int         cmd0 = 0;
  logic [7:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " wen"},   32'(F_WEN_A), 1);
    chk({tag, " ren"},   32'(F_REN_A), 1);
    chk({tag, " cle"},   32'(F_CLE_A), 0);
    chk({tag, " ale"},   32'(F_ALE_A), 0);
    chk({tag, " io"},    32'(flash_io), 32'hFF);
    chk({tag, " busy"},  32'(busy), 0);
    chk({tag, " valid"}, 32'(dout_valid), 0);
    chk({tag, " done"},  32'(page_done), 0);
    chk({tag, " dout"},  32'(dout), 0);
  endtask

  task automatic start_page(input int p);
    @(posedge clk); #2;
    start = 1'b1; page_addr = 9'(p); new_page = 1'b1; exp_page = p; cmd0 = cmd_cnt;
    @(posedge clk); #2;
    start = 1'b0; new_page = 1'b0; page_addr = 9'h0AA;
    chk("start busy", 32'(busy), 1);
    chk("start wen",  32'(F_WEN_A), 0);
    chk("start cle",  32'(F_CLE_A), 1);
  endtask

  task automatic wait_done(input bit gap_chk);
    bit seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (page_done) begin seen = 1'b1; break; end
    end
    chk("page_done seen", 32'(seen), 1);
    chk("busy at done", 32'(busy), 1);
    @(negedge clk); #1;
    chk("busy after done", 32'(busy), 0);
    chk("done pulse width", 32'(page_done), 0);
    chk("handshakes", 32'(hs_cnt), 512);
    chk("data errors", 32'(data_bad), 0);
    chk("hold errors", 32'(hold_bad), 0);
    chk("done count", 32'(done_cnt), 1);
    chk("done after last hs", 32'(done_gap), 1);
    chk("done/hs overlap", 32'(overlap), 0);
    chk("commands issued", 32'(cmd_cnt - cmd0), 1);
    if (gap_chk) begin
      chk("min byte gap", 32'(min_gap), 3);
      chk("max byte gap", 32'(max_gap), 3);
    end
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (hs_cnt >= n) break;
    end
  endtask

  initial begin
    // reset window
    #3 rst = 1'b1;
    #9 chk_reset_outputs("reset");
    #6 rst = 1'b0;

    // page 0
    start_page(0);
    wait_done(1'b1);
    chk("p0 writes", 32'(wr_n), 4);
    chk("p0 cmd",  32'(wr_log[0]), 32'h200);
    chk("p0 col",  32'(wr_log[1]), 32'h100);
    chk("p0 rowl", 32'(wr_log[2]), 32'h100);
    chk("p0 rowh", 32'(wr_log[3]), 32'h100);

    // page 511
    start_page(511);
    wait_done(1'b1);
    chk("p511 writes", 32'(wr_n), 4);
    chk("p511 cmd",  32'(wr_log[0]), 32'h200);
    chk("p511 col",  32'(wr_log[1]), 32'h100);
    chk("p511 rowl", 32'(wr_log[2]), 32'h1FF);
    chk("p511 rowh", 32'(wr_log[3]), 32'h101);
    chk("p511 fl page", 32'(fl_page), 511);

    // backpressure at byte 100 of page 2
    start_page(2);
    wait_hs(100);
    #2 dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dout_valid) break;
    end
    held = dout;
    chk("bp byte", 32'(held), 32'(mem_f(2 * 512 + 100)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp valid", 32'(dout_valid), 1);
      chk("bp dout",  32'(dout), 32'(held));
      chk("bp ren",   32'(F_REN_A), 1);
    end
    @(posedge clk); #2 dout_ready = 1'b1;
    wait_done(1'b0);

    // start pulse mid-page is ignored
    start_page(3);
    wait_hs(256);
    #2 start = 1'b1; page_addr = 9'd7;
    @(posedge clk); #2 start = 1'b0;
    chk("ign busy", 32'(busy), 1);
    wait_done(1'b0);
    chk("ign fl page", 32'(fl_page), 3);

    // reset mid-read, then page 5
    start_page(4);
    wait_hs(200);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #2 rst = 1'b0;
    start_page(5);
    wait_done(1'b1);
    chk("p5 rowl", 32'(wr_log[2]), 32'h105);
    chk("p5 rowh", 32'(wr_log[3]), 32'h100);

    // R/B never falls: WAIT_LO timeout path
    rb_mode = 1'b0;
    start_page(6);
    wait_done(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
